// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if: CP0, decode and fetch signals seen by the exception controller.
interface exc_ctrl_if;
   logic [5:0]  irq_in;
   logic        timer_irq;
   logic [5:0]  intr_out;
   logic [31:0] status;
   logic [31:0] cause;
   logic [31:0] epc;
   logic        id_valid;
   logic        id_syscall;
   logic        id_eret;
   logic [31:0] id_pc;
   logic        pipe_ready;
   logic        stall;
   logic        flush;
   logic [31:0] excptype;
   logic [31:0] exc_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        busy;
   modport master (
      input  irq_in, timer_irq, status, cause, epc, id_valid, id_syscall, id_eret, id_pc, pipe_ready,
      output intr_out, stall, flush, excptype, exc_pc, redirect_valid, redirect_pc, busy
   );
   modport slave (
      output irq_in, timer_irq, status, cause, epc, id_valid, id_syscall, id_eret, id_pc, pipe_ready,
      input  intr_out, stall, flush, excptype, exc_pc, redirect_valid, redirect_pc, busy
   );
endinterface

// File: rtl/exc_ctrl.sv
// exc_ctrl: exception/interrupt sequencer (stall, drain, commit, redirect) feeding CP0.
// EXC_CTRL_IRQ_SYNC_EN selects a 2-flop irq_in synchronizer instead of a single stage.
module exc_ctrl #(
   parameter logic [31:0] EXC_VECTOR    = 32'h0000_0040,
   parameter int unsigned DRAIN_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   exc_ctrl_if.master bus
);
   typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;
   state_t      state_q, state_d;
   logic [31:0] lat_type_q, lat_type_d, lat_pc_q, lat_pc_d;
   logic [31:0] excptype_q, excptype_d, exc_pc_q, exc_pc_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d, flush_q, flush_d, redirect_valid_q, redirect_valid_d;
   logic        irq_pend;
   logic [31:0] ev_type;
   logic [5:0]  sync_q;
   logic        unused_ok;
   assign unused_ok = ^{bus.status[31:16], bus.status[9:2], bus.cause[31:16], bus.cause[9:0]};
   always_comb begin
      irq_pend   = bus.status[0] & ~bus.status[1] & |(bus.cause[15:10] & bus.status[15:10]);
      ev_type    = irq_pend                        ? 32'h004 :
                   (bus.id_valid & bus.id_syscall) ? 32'h100 :
                   (bus.id_valid & bus.id_eret)    ? 32'h200 : 32'h0;
      state_d    = state_q;
      lat_type_d = lat_type_q;
      lat_pc_d   = lat_pc_q;
      cnt_d      = cnt_q;
      case (state_q)
         IDLE: if (ev_type != 32'h0) begin
            state_d    = DRAIN;
            lat_type_d = ev_type;
            lat_pc_d   = bus.id_pc;
            cnt_d      = 8'(DRAIN_TIMEOUT);
         end
         DRAIN: begin
            state_d = (bus.pipe_ready || cnt_q == 8'd0) ? COMMIT : DRAIN;
            cnt_d   = (cnt_q == 8'd0) ? cnt_q : cnt_q - 8'd1;
         end
         COMMIT:  state_d = REDIRECT;
         default: state_d = IDLE;
      endcase
      busy_d           = state_d != IDLE;
      flush_d          = state_d == COMMIT;
      redirect_valid_d = state_d == REDIRECT;
      excptype_d       = flush_d ? lat_type_d : 32'h0;
      exc_pc_d         = flush_d ? lat_pc_d : 32'h0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= IDLE;
         lat_type_q       <= '0;
         lat_pc_q         <= '0;
         cnt_q            <= '0;
         busy_q           <= 1'b0;
         flush_q          <= 1'b0;
         redirect_valid_q <= 1'b0;
         excptype_q       <= '0;
         exc_pc_q         <= '0;
      end else begin
         state_q          <= state_d;
         lat_type_q       <= lat_type_d;
         lat_pc_q         <= lat_pc_d;
         cnt_q            <= cnt_d;
         busy_q           <= busy_d;
         flush_q          <= flush_d;
         redirect_valid_q <= redirect_valid_d;
         excptype_q       <= excptype_d;
         exc_pc_q         <= exc_pc_d;
      end
   end
`ifdef EXC_CTRL_IRQ_SYNC_EN
   logic [5:0] meta_q;
   always_ff @(posedge clk) begin
      meta_q <= rst ? 6'h0 : bus.irq_in;
      sync_q <= rst ? 6'h0 : meta_q;
   end
`else
   always_ff @(posedge clk) sync_q <= rst ? 6'h0 : bus.irq_in;
`endif
   // timer_irq is already synchronous to clk, so it bypasses the sync stage
   assign bus.intr_out       = {sync_q[5] | bus.timer_irq, sync_q[4:0]};
   assign bus.busy           = busy_q;
   assign bus.stall          = busy_q;
   assign bus.flush          = flush_q;
   assign bus.excptype       = excptype_q;
   assign bus.exc_pc         = exc_pc_q;
   assign bus.redirect_valid = redirect_valid_q;
   // eret target reads live epc: CP0 has already updated it on the COMMIT edge
   assign bus.redirect_pc    = !redirect_valid_q ? 32'h0 :
                               (lat_type_q == 32'h200) ? bus.epc : EXC_VECTOR;
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed self-checking bench for exc_ctrl.
module tb_exc_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   int   n;
   exc_ctrl_if bus();
   exc_ctrl dut (.clk(clk), .rst(rst), .bus(bus.master));
   always #5 clk = ~clk;
`ifdef EXC_CTRL_IRQ_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 1;
`endif
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask
   task automatic idle_inputs();
      bus.id_valid   = 1'b0;
      bus.id_syscall = 1'b0;
      bus.id_eret    = 1'b0;
      bus.status     = 32'h0;
      bus.cause      = 32'h0;
   endtask
   initial begin
      bus.irq_in     = 6'h0;
      bus.timer_irq  = 1'b0;
      bus.epc        = 32'h0;
      bus.id_pc      = 32'h0;
      bus.pipe_ready = 1'b1;
      idle_inputs();
      tick();
      tick();
      check("rst_busy", {31'h0, bus.busy}, 32'h0);
      check("rst_stall", {31'h0, bus.stall}, 32'h0);
      check("rst_flush", {31'h0, bus.flush}, 32'h0);
      check("rst_excptype", bus.excptype, 32'h0);
      check("rst_redirect", {31'h0, bus.redirect_valid}, 32'h0);
      check("rst_intr", {26'h0, bus.intr_out}, 32'h0);
      rst = 1'b0;
      tick();
      // syscall with pipeline already drained
      bus.id_valid = 1'b1; bus.id_syscall = 1'b1; bus.id_pc = 32'h100;
      tick();
      idle_inputs();
      check("sys_drain_stall", {31'h0, bus.stall}, 32'h1);
      check("sys_drain_exc", bus.excptype, 32'h0);
      tick();
      check("sys_commit_type", bus.excptype, 32'h100);
      check("sys_commit_pc", bus.exc_pc, 32'h100);
      check("sys_commit_flush", {31'h0, bus.flush}, 32'h1);
      tick();
      check("sys_redir_valid", {31'h0, bus.redirect_valid}, 32'h1);
      check("sys_redir_pc", bus.redirect_pc, 32'h40);
      check("sys_redir_flush", {31'h0, bus.flush}, 32'h0);
      check("sys_redir_exc", bus.excptype, 32'h0);
      tick();
      check("sys_idle_busy", {31'h0, bus.busy}, 32'h0);
      check("sys_idle_redir", {31'h0, bus.redirect_valid}, 32'h0);
      // eret
      bus.id_valid = 1'b1; bus.id_eret = 1'b1; bus.id_pc = 32'h300; bus.epc = 32'h2000;
      tick();
      idle_inputs();
      tick();
      check("eret_commit_type", bus.excptype, 32'h200);
      check("eret_commit_pc", bus.exc_pc, 32'h300);
      tick();
      check("eret_redir_pc", bus.redirect_pc, 32'h2000);
      tick();
      // interrupt: IE=1, EXL=0, IM0=1, IP0=1; IP drops during DRAIN
      bus.status = 32'h0000_0401; bus.cause = 32'h0000_0400; bus.id_pc = 32'h500;
      tick();
      bus.cause = 32'h0;
      check("irq_drain_busy", {31'h0, bus.busy}, 32'h1);
      tick();
      check("irq_commit_type", bus.excptype, 32'h4);
      check("irq_commit_pc", bus.exc_pc, 32'h500);
      tick();
      check("irq_redir_pc", bus.redirect_pc, 32'h40);
      tick();
      // masked by IM=0, then by EXL=1
      bus.status = 32'h0000_0001; bus.cause = 32'h0000_0400;
      tick();
      check("irq_im_masked", {31'h0, bus.busy}, 32'h0);
      bus.status = 32'h0000_0403;
      tick();
      check("irq_exl_masked", {31'h0, bus.busy}, 32'h0);
      // interrupt beats syscall, syscall beats eret
      bus.status = 32'h0000_0401; bus.id_valid = 1'b1; bus.id_syscall = 1'b1; bus.id_eret = 1'b1;
      tick();
      idle_inputs();
      tick();
      check("prio_irq_type", bus.excptype, 32'h4);
      tick(); tick();
      bus.id_valid = 1'b1; bus.id_syscall = 1'b1; bus.id_eret = 1'b1;
      tick();
      idle_inputs();
      tick();
      check("prio_sys_type", bus.excptype, 32'h100);
      tick(); tick();
      // drain timeout: pipe never ready
      bus.pipe_ready = 1'b0;
      bus.id_valid = 1'b1; bus.id_syscall = 1'b1;
      tick();
      idle_inputs();
      n = 0;
      while (bus.excptype == 32'h0 && n < 40) begin
         n++;
         tick();
      end
      check("timeout_drain_cycles", n, 32'd16);
      check("timeout_commit_type", bus.excptype, 32'h100);
      tick(); tick();
      // reset mid-DRAIN aborts without an excptype pulse
      bus.id_valid = 1'b1; bus.id_syscall = 1'b1;
      tick();
      idle_inputs();
      tick(); tick();
      check("abort_busy_before", {31'h0, bus.busy}, 32'h1);
      rst = 1'b1;
      tick();
      check("abort_busy", {31'h0, bus.busy}, 32'h0);
      check("abort_stall", {31'h0, bus.stall}, 32'h0);
      check("abort_exc", bus.excptype, 32'h0);
      rst = 1'b0;
      bus.pipe_ready = 1'b1;
      tick();
      check("abort_no_pulse", bus.excptype, 32'h0);
      check("abort_flush", {31'h0, bus.flush}, 32'h0);
      // irq sync latency and unsynchronized timer
      bus.irq_in = 6'h01;
      tick();
      check("sync_first_cycle", {31'h0, bus.intr_out[0]}, (SYNC_LAT == 1) ? 32'h1 : 32'h0);
      tick();
      check("sync_second_cycle", {31'h0, bus.intr_out[0]}, 32'h1);
      bus.timer_irq = 1'b1;
      #1;
      check("timer_bit5", {26'h0, bus.intr_out}, 32'h21);
      bus.timer_irq = 1'b0;
      bus.irq_in = 6'h0;
      tick(); tick();
      check("sync_clear", {26'h0, bus.intr_out}, 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt controller; the producer side of the CP0 interface.
- Synchronizes external interrupt lines and drives the CP0 `intr` input.
- Reads CP0 `status`/`cause`/`epc`, arbitrates interrupt, syscall and eret events from decode, and sequences stall → drain → commit → redirect.
- Drives `excptype` (one-cycle pulse) and `pc` into CP0, plus flush and redirect to fetch.

Parameters:
- EXC_VECTOR, 32'h0000_0040, redirect target for interrupt and syscall entry.
- DRAIN_TIMEOUT, 15, maximum cycles spent in DRAIN before forced commit; range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- irq_in  in  6  raw external interrupt lines, asynchronous, level
- timer_irq  in  1  CP0 timer interrupt (intimer)
- intr_out  out  6  to CP0 intr; bit5 = sync(irq_in[5]) | timer_irq
- status  in  32  CP0 Status; [0]=IE, [1]=EXL, [15:10]=IM
- cause  in  32  CP0 Cause; [15:10]=IP
- epc  in  32  CP0 EPC
- id_valid  in  1  decode slot holds a valid instruction
- id_syscall  in  1  decode instruction is syscall
- id_eret  in  1  decode instruction is eret
- id_pc  in  32  PC of decode instruction
- pipe_ready  in  1  downstream stages drained
- stall  out  1  freeze fetch/decode
- flush  out  1  kill in-flight instructions
- excptype  out  32  to CP0; 0x4 interrupt, 0x100 syscall, 0x200 eret, else 0
- exc_pc  out  32  to CP0 pc
- redirect_valid  out  1  one-cycle fetch redirect strobe
- redirect_pc  out  32  fetch redirect target
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset: FSM=IDLE; sync flops, latched type/pc and timeout counter all 0.
  - All outputs 0 on the cycle after rst is sampled high.
  - rst mid-sequence aborts immediately; no excptype pulse is emitted.
- Interrupt pending: irq_pend = IE & ~EXL & |(cause[15:10] & status[15:10]), evaluated combinationally in IDLE.
- Priority, evaluated in IDLE each cycle: irq_pend > (id_valid & id_syscall) > (id_valid & id_eret).
  - When syscall and eret are both asserted, syscall wins.
  - Losing events are not queued; decode re-presents them after redirect.
- IDLE → DRAIN on any event.
  - Latch type (0x4/0x100/0x200) and id_pc into lat_type/lat_pc.
  - stall=1 from the next cycle.
  - Timeout counter loads DRAIN_TIMEOUT.
- DRAIN: stall=1; counter decrements each cycle.
  - Advance to COMMIT when pipe_ready=1 or counter==0.
  - If pipe_ready and counter==0 coincide, take the same path; no difference in behaviour.
  - Interrupts deasserting during DRAIN do not cancel a latched interrupt.
- COMMIT, exactly 1 cycle: excptype=lat_type, exc_pc=lat_pc, flush=1, stall=1. Next state is REDIRECT.
- REDIRECT, exactly 1 cycle: redirect_valid=1, stall=1, flush=0. Next state is IDLE.
  - redirect_pc = EXC_VECTOR for 0x4/0x100.
  - redirect_pc = epc input sampled this cycle for 0x200; CP0 has already updated on the COMMIT edge.
- excptype and exc_pc are 0 outside COMMIT.
- busy = (state != IDLE).
- No new event is accepted in DRAIN, COMMIT or REDIRECT.
- Minimum latency from event to redirect_valid: 3 cycles (IDLE→DRAIN with pipe_ready=1 → COMMIT → REDIRECT).
- Back-to-back events: IDLE may accept a new event on the cycle after REDIRECT.
  - After interrupt entry EXL=1 (set by CP0), so the same interrupt is not retaken.

Optional Feature:
- Macro: EXC_CTRL_IRQ_SYNC_EN.
- Defined: irq_in passes through a 2-flop synchronizer before intr_out; irq_in to intr_out latency is 2 cycles.
- Undefined: single register stage; latency is 1 cycle.
- timer_irq is never synchronized; it is ORed after the sync stage in both builds.

Test Plan:
- Reset: assert rst mid-DRAIN of a syscall → next cycle busy=0, stall=0, no excptype pulse; all outputs 0.
- Syscall: id_valid=1, id_syscall=1, id_pc=0x100, pipe_ready=1 → COMMIT shows excptype=0x100, exc_pc=0x100, flush=1; then redirect_pc=0x40 one cycle later.
- Eret: id_eret=1, epc=0x2000 → excptype=0x200 pulse, then redirect_pc=0x2000.
- Interrupt masking: IE=1, EXL=0, IM=6'b000001, IP=6'b000001 → excptype=0x4.
  - Same with IM=0, or with EXL=1 → no event, busy stays 0.
- Drain timeout: event with pipe_ready held 0 → COMMIT after exactly DRAIN_TIMEOUT+1 DRAIN cycles (16 at default).
- Priority and sync latency:
  - Interrupt and syscall in the same cycle → excptype=0x4 only.
  - irq_in[0] 0→1 → intr_out[0] rises 2 cycles later with EXC_CTRL_IRQ_SYNC_EN defined, 1 cycle without.
